// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl: AES-128 key expansion sequencer.
// Loads a 128-bit cipher key, then runs one key_schedule step per clock
// to fill round keys 0..NR. The round datapath reads them through an
// indexed port.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start_i        request expansion of key_i (pulse or level)
//   key_i          cipher key, row-major (row0 in MSBs)
//   zeroize_i      clear all key material (only with KEY_EXP_ZEROIZE_EN)
//   busy_o         expansion in progress
//   keys_valid_o   all NR+1 round keys stored and stable
//   rd_idx_i       round key index to read (0..NR, larger reads 0)
//   rd_key_o       round key rd_idx_i, same packing as key_i
// Optional feature macro: KEY_EXP_ZEROIZE_EN (adds zeroize_i).

// One AES-128 key schedule round, purely combinational, row-major packing.
module key_schedule (
   input  logic [7:0]   round_num,
   input  logic [127:0] key_i,
   output logic [127:0] key_o
);
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int i = 0; i < 7; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
               ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   logic [31:0] w   [4];
   logic [31:0] n   [4];
   logic [31:0] tmp;
   logic [7:0]  rcon;

   always_comb begin
      rcon = 8'h00;
      case (round_num)
         8'd1:    rcon = 8'h01;
         8'd2:    rcon = 8'h02;
         8'd3:    rcon = 8'h04;
         8'd4:    rcon = 8'h08;
         8'd5:    rcon = 8'h10;
         8'd6:    rcon = 8'h20;
         8'd7:    rcon = 8'h40;
         8'd8:    rcon = 8'h80;
         8'd9:    rcon = 8'h1b;
         8'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   always_comb begin
      // unpack rows into column words
      for (int c = 0; c < 4; c++) begin
         w[c] = {key_i[127-8*c -: 8], key_i[95-8*c -: 8],
                 key_i[63-8*c -: 8],  key_i[31-8*c -: 8]};
      end
      tmp  = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])}
             ^ {rcon, 24'h000000};
      n[0] = w[0] ^ tmp;
      n[1] = w[1] ^ n[0];
      n[2] = w[2] ^ n[1];
      n[3] = w[3] ^ n[2];
      key_o = '0;
      for (int c = 0; c < 4; c++) begin
         key_o[127-8*c -: 8] = n[c][31:24];
         key_o[95-8*c -: 8]  = n[c][23:16];
         key_o[63-8*c -: 8]  = n[c][15:8];
         key_o[31-8*c -: 8]  = n[c][7:0];
      end
   end
endmodule

module key_expansion_ctrl #(
   parameter int unsigned NR     = 10,
   parameter bit          RD_REG = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [127:0] key_i,
`ifdef KEY_EXP_ZEROIZE_EN
   input  logic         zeroize_i,
`endif
   output logic         busy_o,
   output logic         keys_valid_o,
   input  logic [3:0]   rd_idx_i,
   output logic [127:0] rd_key_o
);
   localparam int unsigned KW = 128;
   localparam int unsigned CW = 4;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EXPAND = 2'd1;
   localparam logic [1:0] READY  = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [CW-1:0] cnt;
   logic [KW-1:0] rk [0:NR];
   logic [KW-1:0] prev_key;
   logic [KW-1:0] next_key;
   logic [KW-1:0] rd_sel;
   logic [7:0]    round_num;
   logic          load_c;
   logic          step_c;
   logic          done_c;
   logic          zero_c;

`ifdef KEY_EXP_ZEROIZE_EN
   assign zero_c = zeroize_i;
`else
   assign zero_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and datapath control
   always_comb begin
      state_nxt = state;
      load_c    = 1'b0;
      step_c    = 1'b0;
      done_c    = 1'b0;
      if (zero_c) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, READY: begin
               if (start_i) begin
                  load_c    = 1'b1;
                  state_nxt = EXPAND;
               end
            end
            EXPAND: begin
               step_c = 1'b1;
               if (cnt == CW'(NR)) begin
                  done_c    = 1'b1;
                  state_nxt = READY;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Schedule input: previous key selected by the registered counter
   always_comb begin
      prev_key = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (cnt == CW'(i + 1)) prev_key = rk[i];
      end
   end

   assign round_num = (state == EXPAND) ? {4'b0000, cnt} : 8'h00;

   key_schedule u_key_schedule (
      .round_num (round_num),
      .key_i     (prev_key),
      .key_o     (next_key)
   );

   // Round key storage, counter and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         busy_o       <= 1'b0;
         keys_valid_o <= 1'b0;
         for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
      end else begin
         busy_o       <= (state_nxt == EXPAND);
         keys_valid_o <= (state_nxt == READY);
         if (zero_c) begin
            cnt <= '0;
            for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
         end else if (load_c) begin
            rk[0] <= key_i;
            cnt   <= CW'(1);
         end else if (step_c) begin
            for (int unsigned i = 1; i <= NR; i++) begin
               if (cnt == CW'(i)) rk[i] <= next_key;
            end
            cnt <= done_c ? '0 : cnt + CW'(1);
         end
      end
   end

   // Indexed read; out-of-range indices return zero
   always_comb begin
      rd_sel = '0;
      for (int unsigned i = 0; i <= NR; i++) begin
         if (rd_idx_i == CW'(i)) rd_sel = rk[i];
      end
   end

   generate
      if (RD_REG) begin : g_rd_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      rd_key_o <= '0;
            else if (zero_c) rd_key_o <= '0;
            else             rd_key_o <= rd_sel;
         end
      end else begin : g_rd_comb
         assign rd_key_o = rd_sel;
      end
   endgenerate
endmodule
